// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage stall requests, EX/ID hazard operands and EX redirect in,
// per-register holds, flush, PC load and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall_req_if_i;
    logic              stall_req_id_i;
    logic              stall_req_ex_i;
    logic              stall_req_mem_i;
    logic              ex_is_ld_i;
    logic              ex_w_enable_i;
    logic [4:0]        ex_w_addr_i;
    logic              id_r1_read_i;
    logic [4:0]        id_r1_addr_i;
    logic              id_r2_read_i;
    logic [4:0]        id_r2_addr_i;
    logic              ex_b_flag_i;
    logic [ADDR_W-1:0] ex_b_target_i;
    logic [4:0]        stall_o;
    logic              flush_o;
    logic              pc_load_o;
    logic [ADDR_W-1:0] pc_target_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  redir_cnt_o;

    modport master (
        output stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
        output ex_is_ld_i, ex_w_enable_i, ex_w_addr_i,
        output id_r1_read_i, id_r1_addr_i, id_r2_read_i, id_r2_addr_i,
        output ex_b_flag_i, ex_b_target_i,
        input  stall_o, flush_o, pc_load_o, pc_target_o, stall_cnt_o, redir_cnt_o
    );

    modport slave (
        input  stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
        input  ex_is_ld_i, ex_w_enable_i, ex_w_addr_i,
        input  id_r1_read_i, id_r1_addr_i, id_r2_read_i, id_r2_addr_i,
        input  ex_b_flag_i, ex_b_target_i,
        output stall_o, flush_o, pc_load_o, pc_target_o, stall_cnt_o, redir_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer around EX: merges stage stall requests, load-use detection and branch redirects
// into hold bits, flush and PC load, with saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int LU_BUBBLES   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int MAXC = (LU_BUBBLES > FLUSH_CYCLES) ? LU_BUBBLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [1:0] {RUN, LU_WAIT, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;
    logic              lu;
    logic [4:0]        stall;
    logic              flush;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    assign lu = bus.ex_is_ld_i && bus.ex_w_enable_i && (bus.ex_w_addr_i != 5'd0) &&
                ((bus.id_r1_read_i && (bus.id_r1_addr_i == bus.ex_w_addr_i)) ||
                 (bus.id_r2_read_i && (bus.id_r2_addr_i == bus.ex_w_addr_i)));

    always_comb begin
        stall     = 5'b00000;
        flush     = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!rst) begin
            flush   = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
        end else if (bus.stall_req_mem_i) begin
            stall = 5'b01111;
        end else if (bus.stall_req_ex_i) begin
            // EX is held, so a pending branch is re-evaluated once EX is released
            stall = 5'b00111;
        end else begin
            case (state_q)
                LU_WAIT: begin
                    stall = 5'b00011;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                FLUSH: begin
                    flush = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    if (bus.ex_b_flag_i) begin
                        flush     = 1'b1;
                        pc_load   = 1'b1;
                        pc_target = bus.ex_b_target_i;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = CW'(FLUSH_CYCLES - 1);
                        end
                    end else if (lu || bus.stall_req_id_i) begin
                        stall = 5'b00011;
                        if (lu && (LU_BUBBLES > 1)) begin
                            state_d = LU_WAIT;
                            cnt_d   = CW'(LU_BUBBLES - 1);
                        end
                    end else if (bus.stall_req_if_i) begin
                        stall = 5'b00001;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (stall[0] && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (pc_load && (redir_cnt_q != {CNT_W{1'b1}})) redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.pc_load_o   = pc_load;
    assign bus.pc_target_o = pc_target;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.redir_cnt_o = redir_cnt_q;
endmodule
